// File: rtl/regfile_sb_pkg.sv
// Shared defaults and sizing helper for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 4;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks outstanding destination writes and gates issue
// on RAW (source) and WAW (destination) hazards.
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ADDRW    = addr_w(DEF_NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [ADDRW-1:0] rd_addr1,
  input  logic [ADDRW-1:0] rd_addr2,
  input  logic             rd_use1,
  input  logic             rd_use2,
  input  logic             iss_valid,
  input  logic             iss_wr,
  input  logic [ADDRW-1:0] iss_dst,
  output logic             iss_ready,
  output logic [ADDRW:0]   pending_cnt
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDRW:0]   cnt_q, cnt_d;
  logic             blk_src1, blk_src2, blk_dst;

  // A source waiting on the register being written back this cycle is only
  // released when the write data can be forwarded.
  always_comb begin
    blk_src1  = rd_use1 && busy_q[rd_addr1] && !(BP && we && (wr_addr == rd_addr1));
    blk_src2  = rd_use2 && busy_q[rd_addr2] && !(BP && we && (wr_addr == rd_addr2));
    blk_dst   = iss_wr && busy_q[iss_dst] && !(we && (wr_addr == iss_dst));
    iss_ready = !(blk_src1 || blk_src2 || blk_dst);
  end

  // Set is applied after clear so a same-cycle issue to the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[wr_addr] = 1'b0;
    if (iss_valid && iss_ready && iss_wr) busy_d[iss_dst] = 1'b1;
    if (ZR) busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + {{ADDRW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with optional zero register and write-to-read bypass, plus
// a busy-bit scoreboard that decides whether an instruction may issue.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  ZERO_REG = 0,
  parameter int  BYPASS   = 1,
  localparam int ADDRW    = addr_w(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDRW-1:0]   wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [ADDRW-1:0]   rd_addr1,
  input  logic [ADDRW-1:0]   rd_addr2,
  output logic [WIDTH-1:0]   rd_data1,
  output logic [WIDTH-1:0]   rd_data2,
  input  logic               rd_use1,
  input  logic               rd_use2,
  input  logic               iss_valid,
  input  logic               iss_wr,
  input  logic [ADDRW-1:0]   iss_dst,
  output logic               iss_ready,
  output logic [ADDRW:0]     pending_cnt,
  output logic [NREGS*WIDTH-1:0] dbg_regs
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             wr_en;

  // Writes aimed at the hard-wired zero register are dropped entirely.
  assign wr_en = we && !(ZR && (wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (BP && wr_en && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
    if (ZR && (rd_addr1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (BP && wr_en && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
    if (ZR && (rd_addr2 == '0)) rd_data2 = '0;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_dbg
    assign dbg_regs[g*WIDTH +: WIDTH] = regs_q[g];
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDRW    (ADDRW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .wr_addr     (wr_addr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_use1     (rd_use1),
    .rd_use2     (rd_use2),
    .iss_valid   (iss_valid),
    .iss_wr      (iss_wr),
    .iss_dst     (iss_dst),
    .iss_ready   (iss_ready),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per register (>=1).
REQ-002 SHALL have parameter NREGS, default 4, register count, power of two, >=2; ADDRW = clog2(NREGS).
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = register 0 reads as 0, writes to it discarded, never busy.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to read ports.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: we  in  1  writeback strobe; wr_addr  in  ADDRW  writeback register; wr_data  in  WIDTH  writeback data.
REQ-007 SHALL have ports: rd_addr1, rd_addr2  in  ADDRW  read selects; rd_data1, rd_data2  out  WIDTH  read data.
REQ-008 SHALL have ports: rd_use1, rd_use2  in  1  operand actually consumed by issuing instruction.
REQ-009 SHALL have ports: iss_valid  in  1  instruction issue request; iss_wr  in  1  instruction will write a register; iss_dst  in  ADDRW  its destination.
REQ-010 SHALL have ports: iss_ready  out  1  issue accepted this cycle when high with iss_valid; pending_cnt  out  ADDRW+1  number of busy registers.
REQ-011 SHALL have port: dbg_regs  out  NREGS*WIDTH  all register contents, register i at bits [i*WIDTH +: WIDTH].

Function
REQ-012 Storage SHALL update on rising clk when we=1: regs[wr_addr] <= wr_data (except reg 0 when ZERO_REG=1).
REQ-013 Reads SHALL be combinational from regs; with BYPASS=1 and we=1 and rd_addrN==wr_addr (and not the discarded reg 0), rd_dataN SHALL equal wr_data in the same cycle.
REQ-014 Each register SHALL have a busy bit; an accepted issue (iss_valid & iss_ready & iss_wr) SHALL set busy[iss_dst] at the next edge.
REQ-015 we=1 SHALL clear busy[wr_addr] at the next edge; a write to a non-busy register SHALL still update data and leave busy 0.
REQ-016 If accepted issue sets and writeback clears the same register in one cycle, set SHALL win (busy=1 after edge).
REQ-017 RAW: source N SHALL be blocked when rd_useN=1 and busy[rd_addrN]=1, unless BYPASS=1 and we=1 and wr_addr==rd_addrN.
REQ-018 WAW: destination SHALL be blocked when iss_wr=1 and busy[iss_dst]=1 and not (we=1 and wr_addr==iss_dst).
REQ-019 iss_ready SHALL be 1 exactly when neither source nor destination is blocked; combinational, independent of iss_valid.
REQ-020 pending_cnt SHALL be a registered popcount of busy bits, matching busy state after each edge (0..NREGS).
REQ-021 With ZERO_REG=1, register 0 SHALL never block, never become busy, and always read 0 (including bypass).

Reset
REQ-022 rst=1 SHALL asynchronously clear all registers, all busy bits and pending_cnt to 0; iss_ready SHALL then be 1, rd_data1/2 = 0 when we=0.
REQ-023 rst asserted mid-operation SHALL discard pending writebacks and busy state; no write occurs on an edge with rst=1.

Structure
REQ-024 Shared package SHALL hold defaults for WIDTH/NREGS and an ADDRW clog2 helper; no typedefs required.
REQ-025 One sub-module, rf_scoreboard (busy bits, hazard checks, pending_cnt), SHALL be instantiated; storage and read mux stay in top.

Verification
REQ-026 Reset then we=1, wr_addr=2, wr_data=16'hBEEF, rd_addr1=2 same cycle -> rd_data1=16'hBEEF same cycle (BYPASS=1); 16'h0000 with BYPASS=0 until next cycle.
REQ-027 Issue iss_wr=1, iss_dst=1 accepted -> pending_cnt=1; next issue rd_use1=1, rd_addr1=1 -> iss_ready=0 until we to reg 1 (iss_ready=1 in that writeback cycle with BYPASS=1).
REQ-028 busy[3]=1; same cycle we to reg 3 and accepted issue iss_dst=3 -> busy[3]=1, pending_cnt unchanged.
REQ-029 ZERO_REG=1: we=1 wr_addr=0 wr_data=16'h1234 -> rd_data1 (rd_addr1=0) stays 0; issue iss_dst=0 never blocks; pending_cnt stays 0.
REQ-030 NREGS=8, WIDTH=32: issue to all 8 registers -> pending_cnt=8; assert rst mid-stream -> all busy 0, dbg_regs all 0, iss_ready=1 immediately.
REQ-031 Write 16'hAAAA to reg 1 then write reg 1 again with 16'h5555 when not busy -> data 16'h5555, pending_cnt stays 0.
